// File: rtl/pim_conv_sched.sv
// Bit-serial scheduler for one PIM crossbar conv unit: streams feature bit-planes
// per column address, shift-accumulates the ADC codes and emits one result per address.
module pim_conv_sched #(
   parameter int INPUT_SIZE = 16,
   parameter int INPUT_P    = 8,
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = 2,
   parameter int ADC_P      = 5,
   parameter int OUT_P      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [INPUT_SIZE*INPUT_P-1:0] in_feature,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [INPUT_SIZE-1:0]         xb_bits,
   output logic [ADDR_W-1:0]             xb_addr,
   output logic                          xb_en,
   input  logic [ADC_P-1:0]              xb_result,
   output logic [OUT_P-1:0]              out_data,
   output logic [ADDR_W-1:0]             out_addr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done
);

   // state  | meaning
   // IDLE   | waiting for a feature vector
   // ISSUE  | one bit-plane per cycle to the crossbar, LSB first
   // DRAIN  | absorbs the ADC code of the last bit-plane
   // OUT    | result for addr offered, held until accepted
   // DONE   | one-cycle done pulse, back to IDLE

   localparam int BIT_W = (INPUT_P > 1) ? $clog2(INPUT_P) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_OUT,
      S_DONE
   } state_t;

   state_t                        state, state_nxt;
   logic [INPUT_SIZE*INPUT_P-1:0] feature;
   logic [ADDR_W-1:0]             addr;
   logic [BIT_W-1:0]              bit_cnt;
   logic [BIT_W-1:0]              acc_sh;
   logic                          acc_en;
   logic [OUT_P-1:0]              acc;
   logic [OUT_P-1:0]              term;
   logic                          accept;
   logic                          next_addr;
   logic                          bit_last;
   logic                          addr_last;

   assign bit_last  = (bit_cnt == BIT_W'(INPUT_P - 1));
   assign addr_last = (addr == ADDR_W'(DEPTH - 1));
   assign accept    = in_valid & in_ready;
   assign next_addr = (state == S_OUT) & out_ready & ~addr_last;
   assign term      = OUT_P'(xb_result) << acc_sh;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      xb_en     = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            // gated by rst so in_ready stays low while reset is held
            in_ready = rst;
            if (in_valid && rst) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            xb_en = 1'b1;
            if (bit_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: state_nxt = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = addr_last ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         feature <= '0;
         addr    <= '0;
         bit_cnt <= '0;
         acc_sh  <= '0;
         acc_en  <= 1'b0;
         acc     <= '0;
      end else begin
         // ADC code arrives one cycle after its strobe; remember which plane it was
         acc_en <= xb_en;
         acc_sh <= bit_cnt;
         if (accept) begin
            feature <= in_feature;
            addr    <= '0;
            bit_cnt <= '0;
         end else if (state == S_ISSUE) begin
            bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
         end else if (next_addr) begin
            addr    <= addr + ADDR_W'(1);
            bit_cnt <= '0;
         end
         if (accept || next_addr) acc <= '0;
         else if (acc_en)         acc <= acc + term;
      end
   end

   always_comb begin
      xb_bits = '0;
      for (int k = 0; k < INPUT_SIZE; k++)
         xb_bits[k] = (state == S_ISSUE) & feature[k*INPUT_P + int'(bit_cnt)];
   end

   assign xb_addr  = addr;
   assign out_addr = addr;
   assign out_data = (state == S_OUT) ? acc : '0;
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_pim_conv_sched.sv
// Scoreboard bench for pim_conv_sched: a popcount crossbar model feeds two instances
// (two-address job with 16-bit results, single-address job with 5-bit truncating results).
module tb_pim_conv_sched;
   localparam int IS = 4, IP = 4, DP = 2, AW = 2, AP = 5, OP = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [IS*IP-1:0] in_feature;
   logic             in_valid, in_ready;
   logic [IS-1:0]    xb_bits;
   logic [AW-1:0]    xb_addr;
   logic             xb_en;
   logic [AP-1:0]    xb_result;
   logic [OP-1:0]    out_data;
   logic [AW-1:0]    out_addr;
   logic             out_valid, out_ready, busy, done;

   logic [IS*IP-1:0] in_feature2;
   logic             in_valid2, in_ready2;
   logic [IS-1:0]    xb_bits2;
   logic [0:0]       xb_addr2;
   logic             xb_en2;
   logic [AP-1:0]    xb_result2;
   logic [4:0]       out_data2;
   logic [0:0]       out_addr2;
   logic             out_valid2, out_ready2, busy2, done2;

   pim_conv_sched #(.INPUT_SIZE(IS), .INPUT_P(IP), .DEPTH(DP), .ADDR_W(AW),
                    .ADC_P(AP), .OUT_P(OP)) dut (
      .clk(clk), .rst(rst), .in_feature(in_feature), .in_valid(in_valid),
      .in_ready(in_ready), .xb_bits(xb_bits), .xb_addr(xb_addr), .xb_en(xb_en),
      .xb_result(xb_result), .out_data(out_data), .out_addr(out_addr),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

   pim_conv_sched #(.INPUT_SIZE(IS), .INPUT_P(IP), .DEPTH(1), .ADDR_W(1),
                    .ADC_P(AP), .OUT_P(5)) dut2 (
      .clk(clk), .rst(rst), .in_feature(in_feature2), .in_valid(in_valid2),
      .in_ready(in_ready2), .xb_bits(xb_bits2), .xb_addr(xb_addr2), .xb_en(xb_en2),
      .xb_result(xb_result2), .out_data(out_data2), .out_addr(out_addr2),
      .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2), .done(done2));

   function automatic logic [IS-1:0] weight(input logic [AW-1:0] a);
      return (a == 0) ? 4'b1111 : 4'b0101;
   endfunction

   always @(posedge clk) begin
      xb_result  <= AP'($countones(xb_bits & weight(xb_addr)));
      xb_result2 <= AP'($countones(xb_bits2 & 4'b1111));
   end

   int tests = 0, fails = 0;
   int exp_addr_q[$], exp_data_q[$], exp2_q[$];
   int done_cnt = 0, done2_cnt = 0, run = 0, xb_total = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // monitor: pops the scoreboard on every output handshake, tracks strobes and done
   always @(negedge clk) begin
      if (done)  done_cnt++;
      if (done2) done2_cnt++;
      if (xb_en) xb_total++;
      if (out_valid && out_ready) begin
         if (exp_addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_unexpected: got addr %0d data %0d, expected none", out_addr, out_data);
         end else begin
            check("out_addr", int'(out_addr), exp_addr_q.pop_front());
            check("out_data", int'(out_data), exp_data_q.pop_front());
         end
      end
      if (out_valid2 && out_ready2) begin
         if (exp2_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out2_unexpected: got data %0d, expected none", out_data2);
         end else begin
            check("out2_data", int'(out_data2), exp2_q.pop_front());
            check("out2_addr", int'(out_addr2), 0);
         end
      end
      if (!rst) run = 0;
      else if (xb_en) run++;
      else if (run != 0) begin
         check("xb_en_run", run, IP);
         run = 0;
      end
   end

   task automatic push_exp(input int a, input int d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endtask

   task automatic send_job(input logic [IS*IP-1:0] f, input logic [IS-1:0] plane0);
      @(posedge clk); #1;
      in_feature = f;
      in_valid   = 1'b1;
      @(negedge clk);
      check("accept_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("first_xb_en", int'(xb_en), 1);
      check("first_plane", int'(xb_bits), int'(plane0));
      check("first_addr", int'(xb_addr), 0);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeout_fail("wait_out");
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) timeout_fail(name);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0;
      in_feature  = '0; in_valid  = 1'b0; out_ready  = 1'b1;
      in_feature2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

      // reset and idle
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_xb_en", int'(xb_en), 0);
      check("rst_out_valid", int'(out_valid), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_done", int'(done), 0);
      repeat (4) @(negedge clk);
      check("idle_no_xb_en", xb_total, 0);

      // basic job: features {3,5,0,15}
      push_exp(0, 23); push_exp(1, 3);
      d0 = done_cnt;
      send_job(16'hF053, 4'b1011);
      wait_out(n);
      check("lat_en_to_valid", n, IP + 1);
      wait_done("basic_done");
      check("basic_done_once", done_cnt - d0, 1);
      check("ready_after_done", int'(in_ready), 1);
      check("busy_after_done", int'(busy), 0);
      check("basic_xb_en_count", xb_total, 2 * IP);

      // backpressure on addr0
      out_ready = 1'b0;
      push_exp(0, 23); push_exp(1, 3);
      d0 = done_cnt;
      send_job(16'hF053, 4'b1011);
      wait_out(n);
      for (int i = 0; i < 5; i++) begin
         check("stall_data", int'(out_data), 23);
         check("stall_addr", int'(out_addr), 0);
         check("stall_xb_en", int'(xb_en), 0);
         @(negedge clk);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("resume_xb_en", int'(xb_en), 1);
      check("resume_addr", int'(xb_addr), 1);
      wait_done("bp_done");
      check("bp_done_once", done_cnt - d0, 1);

      // input offered while busy is ignored
      push_exp(0, 23); push_exp(1, 3);
      d0 = done_cnt;
      send_job(16'hF053, 4'b1011);
      @(posedge clk); #1;
      in_feature = 16'hFFFF;
      in_valid   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("busy_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_feature = '0;
      wait_done("busy_in_done");
      check("busy_in_done_once", done_cnt - d0, 1);

      // reset during ISSUE of addr1
      push_exp(0, 23);
      d0 = done_cnt;
      send_job(16'hF053, 4'b1011);
      n = 0;
      while (!(xb_en && xb_addr == 1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(xb_en && xb_addr == 1)) timeout_fail("wait_addr1_issue");
      #1 rst = 1'b0;
      #1;
      check("mid_rst_xb_en", int'(xb_en), 0);
      check("mid_rst_xb_bits", int'(xb_bits), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_in_ready", int'(in_ready), 0);
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_out_data", int'(out_data), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_no_done", done_cnt - d0, 0);
      check("mid_rst_queue", exp_addr_q.size(), 0);

      // fresh job after reset, all features at max
      push_exp(0, 60); push_exp(1, 30);
      d0 = done_cnt;
      send_job(16'hFFFF, 4'b1111);
      wait_done("max_done");
      check("max_done_once", done_cnt - d0, 1);

      // single-address instance with 5-bit accumulator: 60 mod 32
      exp2_q.push_back(28);
      d0 = done2_cnt;
      @(posedge clk); #1;
      in_feature2 = 16'hFFFF;
      in_valid2   = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 0;
      while (!done2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done2) timeout_fail("trunc_done");
      @(negedge clk);
      check("trunc_done_once", done2_cnt - d0, 1);
      check("trunc_ready", int'(in_ready2), 1);

      check("queue_empty", exp_addr_q.size(), 0);
      check("queue2_empty", exp2_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
